im_loader: RTL

Program loader and the write side of the instruction memory, which the processor otherwise only reads through the program counter. It accepts a byte stream with a valid/ready handshake and frames it as a 16-bit word count, N instruction words and a checksum. It assembles 32-bit instructions and writes them into instruction memory at consecutive word addresses from 0. It holds the processor in reset until a load completes with a good checksum.

---
 rtl/im_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// ----------------------------------------------------------------------------
// im_loader
//   Program loader and write side of the instruction memory. Receives a byte
//   stream (valid/ready) framed as a 16-bit big-endian word count, N 32-bit
//   big-endian instruction words and a one-byte XOR checksum. Each assembled
//   word is written to consecutive instruction memory word addresses from 0.
//   The processor core is held in reset until a load ends with a good checksum.
//
// Parameters
//   ADDR_W      instruction memory word-address width (max 2^ADDR_W words)
//
// Ports
//   clk         system clock, rising edge
//   rst_f       synchronous active-low reset
//   start       one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   byte_in     stream byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts byte_in this cycle
//   im_waddr    instruction memory write word address
//   im_wdata    instruction word to write
//   im_we       instruction memory write enable, one cycle per word
//   cpu_rst_f   active-low processor reset, high only in DONE
//   busy        load in progress
//   done        load finished with good checksum (held)
//   err         load failed (held)
//   word_count  words written in the current or last load
// ----------------------------------------------------------------------------
module im_loader #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              im_we,
    output logic              cpu_rst_f,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_nx;
    logic [15:0] count;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] word_sr;
    logic        accept;
    logic        start_ok;
    logic [15:0] hdr_count;
    logic        oversize;
    logic [15:0] wc_inc;

    // Ready is a pure function of state so accept does not loop back into
    // the next-state logic.
    assign byte_ready = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                        (state == S_DATA)   || (state == S_CHK);
    assign accept     = byte_valid && byte_ready;
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) ||
                                  (state == S_ERR));

    // Full header value including the low byte being accepted this cycle.
    assign hdr_count = {count[15:8], byte_in};
    assign oversize  = 32'(hdr_count) > (32'd1 << ADDR_W);
    assign wc_inc    = word_count + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        im_we     = 1'b0;
        cpu_rst_f = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (accept) state_nx = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (accept) begin
                    if (oversize)              state_nx = S_ERR;
                    else if (hdr_count == '0)  state_nx = S_CHK;
                    else                       state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd3)) state_nx = S_WRITE;
            end
            S_WRITE: begin
                im_we    = 1'b1;
                state_nx = (wc_inc == count) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (accept) state_nx = (byte_in == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                cpu_rst_f = 1'b1;
                if (start) state_nx = S_HDR_HI;
            end
            S_ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) state_nx = S_HDR_HI;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Write address/data are registered when the last byte of a word is
    // accepted, so they are stable during the WRITE cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            count      <= '0;
            csum       <= '0;
            byte_idx   <= '0;
            word_sr    <= '0;
            word_count <= '0;
            im_waddr   <= '0;
            im_wdata   <= '0;
        end else begin
            if (start_ok) begin
                word_count <= '0;
                csum       <= '0;
            end
            if (accept && (state != S_CHK)) begin
                csum <= csum ^ byte_in;
            end
            case (state)
                S_HDR_HI: if (accept) count[15:8] <= byte_in;
                S_HDR_LO: begin
                    if (accept) begin
                        count[7:0] <= byte_in;
                        byte_idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_sr  <= {word_sr[15:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            im_wdata <= {word_sr, byte_in};
                            im_waddr <= word_count[ADDR_W-1:0];
                        end
                    end
                end
                S_WRITE: word_count <= wc_inc;
                default: ;
            endcase
        end
    end

endmodule
